// File: rtl/seed_random_2_hand_dealer_if.sv
// Hand dealer bus: deal request/clear inputs, upstream card feed and
// hand status outputs. The slave modport is the dealer, master the driver.
interface seed_random_2_hand_dealer_if;
    logic       deal_req_i;
    logic       new_hand_i;
    logic [7:0] card_idx_i;
    logic       req_card_o;
    logic [3:0] card_rank_o;
    logic [4:0] hand_total_o;
    logic [3:0] card_count_o;
    logic       deal_ack_o;
    logic       deal_rej_o;
    logic       busy_o;
    logic       bust_o;
    logic       blackjack_o;

    modport slave (
        input  deal_req_i, new_hand_i, card_idx_i,
        output req_card_o, card_rank_o, hand_total_o, card_count_o,
               deal_ack_o, deal_rej_o, busy_o, bust_o, blackjack_o
    );

    modport master (
        output deal_req_i, new_hand_i, card_idx_i,
        input  req_card_o, card_rank_o, hand_total_o, card_count_o,
               deal_ack_o, deal_rej_o, busy_o, bust_o, blackjack_o
    );
endinterface

// File: rtl/seed_random_2_hand_dealer.sv
// Blackjack hand dealer. Pulls one card per request from an upstream index
// counter, retries on out-of-range indices and keeps the running hand total.
// Define HD_SOFT_ACE_EN to count aces as 11 with demotion to 1 on overflow
// (and to enable blackjack detection); otherwise aces always count 1.
module seed_random_2_hand_dealer (
    input  logic                          clk_hd_i,
    input  logic                          rst_hd_i,
    seed_random_2_hand_dealer_if.slave    hd
);

    typedef enum logic [2:0] {IDLE, REQ, SAMPLE, ACCUM, ACK} state_t;

    state_t     state;
    logic [7:0] idx_q;

    logic [7:0] rank_m1;
    logic [7:0] rank_rem;
    logic [3:0] rank_c;
    logic [5:0] value_c;
    logic [5:0] sum_c;
    logic [4:0] total_c;
    logic [3:0] count_c;

`ifdef HD_SOFT_ACE_EN
    // Number of aces currently counted as 11 in the hand.
    logic [3:0] soft_cnt;
    logic [3:0] soft_c;
`endif

    // Rank, card value and the new hand total for the card held in idx_q.
    always_comb begin
        rank_m1  = idx_q - 8'd1;
        rank_rem = rank_m1 % 8'd13;
        rank_c   = 4'(rank_rem + 8'd1);
        if (rank_c >= 4'd11)
            value_c = 6'd10;
        else if (rank_c == 4'd1)
`ifdef HD_SOFT_ACE_EN
            value_c = 6'd11;
`else
            value_c = 6'd1;
`endif
        else
            value_c = {2'b00, rank_c};
        sum_c = {1'b0, hd.hand_total_o} + value_c;
`ifdef HD_SOFT_ACE_EN
        soft_c = soft_cnt + ((rank_c == 4'd1) ? 4'd1 : 4'd0);
        // At most one ace is demoted per card.
        if (sum_c > 6'd21 && soft_c != 4'd0) begin
            sum_c  = sum_c - 6'd10;
            soft_c = soft_c - 4'd1;
        end
`endif
        total_c = 5'(sum_c);
        count_c = hd.card_count_o + 4'd1;
    end

    // Deal FSM with all outputs registered; reset and new_hand clear alike.
    always_ff @(posedge clk_hd_i) begin
        if (!rst_hd_i || hd.new_hand_i) begin
            state           <= IDLE;
            idx_q           <= 8'd0;
            hd.req_card_o   <= 1'b0;
            hd.card_rank_o  <= 4'd0;
            hd.hand_total_o <= 5'd0;
            hd.card_count_o <= 4'd0;
            hd.deal_ack_o   <= 1'b0;
            hd.deal_rej_o   <= 1'b0;
            hd.busy_o       <= 1'b0;
            hd.bust_o       <= 1'b0;
            hd.blackjack_o  <= 1'b0;
`ifdef HD_SOFT_ACE_EN
            soft_cnt        <= 4'd0;
`endif
        end else begin
            hd.req_card_o <= 1'b0;
            hd.deal_ack_o <= 1'b0;
            hd.deal_rej_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (hd.deal_req_i) begin
                        if (!hd.bust_o && hd.card_count_o < 4'd11) begin
                            state         <= REQ;
                            hd.req_card_o <= 1'b1;
                            hd.busy_o     <= 1'b1;
                        end else begin
                            hd.deal_rej_o <= 1'b1;
                        end
                    end
                end
                REQ: state <= SAMPLE;
                SAMPLE: begin
                    idx_q <= hd.card_idx_i;
                    if (hd.card_idx_i >= 8'd1 && hd.card_idx_i <= 8'd52) begin
                        state <= ACCUM;
                    end else begin
                        // Out-of-range index: ask upstream for another card.
                        state         <= REQ;
                        hd.req_card_o <= 1'b1;
                    end
                end
                ACCUM: begin
                    state           <= ACK;
                    hd.card_rank_o  <= rank_c;
                    hd.hand_total_o <= total_c;
                    hd.card_count_o <= count_c;
                    hd.bust_o       <= (total_c > 5'd21);
                    hd.deal_ack_o   <= 1'b1;
`ifdef HD_SOFT_ACE_EN
                    soft_cnt        <= soft_c;
                    hd.blackjack_o  <= (count_c == 4'd2) && (total_c == 5'd21);
`endif
                end
                ACK: begin
                    state     <= IDLE;
                    hd.busy_o <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    hd.busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
